ts4231_configurator: RTL and testbench

Power-up configuration sequencer for one TS4231 light-to-digital sensor. It drives the sensor's bidirectional D and E lines through the output-enable/output/input triplets of `inout_face_manager`. It waits for the sensor to report light, writes the 15-bit configuration word bit-serially, reads it back for verification with bounded retries, then releases both lines so the pulse decoder can take over. One instance per sensor face (three per face manager).

---
 rtl/ts4231_pkg.sv | 19 +
 rtl/ts4231_phase_timer.sv | 25 ++
 rtl/ts4231_configurator.sv | 242 ++++++++++++++++++++++++
 tb/tb_ts4231_configurator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ts4231_pkg.sv
// Shared types and constants for the TS4231 configuration sequencer.
package ts4231_pkg;

    localparam int unsigned FRAME_BITS = 15;
    localparam logic [FRAME_BITS-1:0] DEFAULT_CONFIG_WORD = 15'h392B;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_LIGHT,
        WR_START,
        WR_BIT,
        WR_STOP,
        RD_START,
        RD_BIT,
        RD_STOP,
        CHECK
    } state_t;

endpackage

// File: rtl/ts4231_phase_timer.sv
// Half-phase down-counter; pulses phase_done on the last cycle of each half-phase.
module ts4231_phase_timer #(
    parameter int unsigned HALF_TICKS = 48
) (
    input  logic clk_96MHz,
    input  logic reset,
    input  logic run,
    output logic phase_done
);

    localparam int unsigned CNT_W = (HALF_TICKS > 2) ? $clog2(HALF_TICKS) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_96MHz) begin
        if (reset || !run || count == '0) begin
            count <= CNT_W'(HALF_TICKS - 1);
        end else begin
            count <= count - CNT_W'(1);
        end
    end

    assign phase_done = run && (count == '0);

endmodule

// File: rtl/ts4231_configurator.sv
// TS4231 power-up sequencer: wait for light, write config word, read it back,
// retry on mismatch, then release the D/E lines.
module ts4231_configurator
    import ts4231_pkg::*;
#(
    parameter logic [FRAME_BITS-1:0] CONFIG_WORD = DEFAULT_CONFIG_WORD,
    parameter int unsigned HALF_TICKS  = 48,
    parameter int unsigned LIGHT_TICKS = 96000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                  clk_96MHz,
    input  logic                  reset,
    input  logic                  start,
    output logic                  d_oe,
    output logic                  d_out,
    input  logic                  d_in,
    output logic                  e_oe,
    output logic                  e_out,
    input  logic                  e_in,
    output logic                  busy,
    output logic                  configured,
    output logic                  error,
    output logic [FRAME_BITS-1:0] readback
);

    localparam int unsigned LIGHT_W = $clog2(LIGHT_TICKS + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);

    state_t                state, state_nxt;
    logic [1:0]            step, step_nxt;
    logic [3:0]            bit_idx, bit_nxt;
    logic [FRAME_BITS-1:0] shreg, shreg_nxt;
    logic [RETRY_W-1:0]    retry, retry_nxt, retry_inc;
    logic [LIGHT_W-1:0]    light_cnt, light_nxt;
    logic                  cfg_nxt, err_nxt;
    logic [FRAME_BITS-1:0] rb_nxt;
    logic [3:0]            msb_idx;
    logic                  timer_run, phase_done;

    ts4231_phase_timer #(
        .HALF_TICKS(HALF_TICKS)
    ) u_timer (
        .clk_96MHz (clk_96MHz),
        .reset     (reset),
        .run       (timer_run),
        .phase_done(phase_done)
    );

    assign msb_idx   = LAST_BIT - bit_idx;
    assign retry_inc = retry + RETRY_W'(1);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state      <= IDLE;
            step       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            retry      <= '0;
            light_cnt  <= '0;
            configured <= 1'b0;
            error      <= 1'b0;
            readback   <= '0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            bit_idx    <= bit_nxt;
            shreg      <= shreg_nxt;
            retry      <= retry_nxt;
            light_cnt  <= light_nxt;
            configured <= cfg_nxt;
            error      <= err_nxt;
            readback   <= rb_nxt;
        end
    end

    // Line values are a pure function of (state, step); released lines idle high.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        retry_nxt = retry;
        light_nxt = light_cnt;
        cfg_nxt   = configured;
        err_nxt   = error;
        rb_nxt    = readback;
        d_oe      = 1'b0;
        e_oe      = 1'b0;
        d_out     = 1'b1;
        e_out     = 1'b1;
        timer_run = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WAIT_LIGHT;
                    cfg_nxt   = 1'b0;
                    err_nxt   = 1'b0;
                    retry_nxt = '0;
                    light_nxt = '0;
                end
            end
            WAIT_LIGHT: begin
                if (d_in && e_in) begin
                    if (light_cnt == LIGHT_W'(LIGHT_TICKS - 1)) begin
                        state_nxt = WR_START;
                        step_nxt  = '0;
                        light_nxt = '0;
                    end else begin
                        light_nxt = light_cnt + LIGHT_W'(1);
                    end
                end else begin
                    light_nxt = '0;
                end
            end
            WR_START: begin
                d_oe      = 1'b1;
                e_oe      = 1'b1;
                d_out     = (step == 2'd0);
                e_out     = (step != 2'd2);
                timer_run = 1'b1;
                if (phase_done) begin
                    if (step == 2'd2) begin
                        state_nxt = WR_BIT;
                        step_nxt  = '0;
                        bit_nxt   = '0;
                    end else begin
                        step_nxt = step + 2'd1;
                    end
                end
            end
            WR_BIT: begin
                d_oe      = 1'b1;
                e_oe      = 1'b1;
                d_out     = CONFIG_WORD[msb_idx];
                e_out     = (step == 2'd1);
                timer_run = 1'b1;
                if (phase_done) begin
                    if (step == 2'd2) begin
                        step_nxt = '0;
                        if (bit_idx == LAST_BIT) begin
                            state_nxt = WR_STOP;
                        end else begin
                            bit_nxt = bit_idx + 4'd1;
                        end
                    end else begin
                        step_nxt = step + 2'd1;
                    end
                end
            end
            WR_STOP: begin
                d_oe      = 1'b1;
                e_oe      = 1'b1;
                d_out     = (step == 2'd2);
                e_out     = (step != 2'd0);
                timer_run = 1'b1;
                if (phase_done) begin
                    if (step == 2'd2) begin
                        state_nxt = RD_START;
                        step_nxt  = '0;
                    end else begin
                        step_nxt = step + 2'd1;
                    end
                end
            end
            RD_START: begin
                // Step 3 is the single cycle that releases D with its low value held.
                d_oe  = (step != 2'd3);
                e_oe  = 1'b1;
                d_out = (step == 2'd0);
                e_out = (step < 2'd2);
                if (step == 2'd3) begin
                    state_nxt = RD_BIT;
                    step_nxt  = '0;
                    bit_nxt   = '0;
                end else begin
                    timer_run = 1'b1;
                    if (phase_done) begin
                        step_nxt = step + 2'd1;
                    end
                end
            end
            RD_BIT: begin
                // E rises, is held a second half-phase, D is sampled at its end, then E falls.
                d_out     = 1'b0;
                e_oe      = 1'b1;
                e_out     = (step != 2'd2);
                timer_run = 1'b1;
                if (phase_done) begin
                    if (step == 2'd1) begin
                        shreg_nxt = {shreg[FRAME_BITS-2:0], d_in};
                    end
                    if (step == 2'd2) begin
                        step_nxt = '0;
                        if (bit_idx == LAST_BIT) begin
                            state_nxt = RD_STOP;
                        end else begin
                            bit_nxt = bit_idx + 4'd1;
                        end
                    end else begin
                        step_nxt = step + 2'd1;
                    end
                end
            end
            RD_STOP: begin
                d_oe      = 1'b1;
                e_oe      = 1'b1;
                d_out     = (step == 2'd2);
                e_out     = (step != 2'd0);
                timer_run = 1'b1;
                if (phase_done) begin
                    if (step == 2'd2) begin
                        state_nxt = CHECK;
                        step_nxt  = '0;
                        rb_nxt    = shreg;
                    end else begin
                        step_nxt = step + 2'd1;
                    end
                end
            end
            CHECK: begin
                if (readback == CONFIG_WORD) begin
                    cfg_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    retry_nxt = retry_inc;
                    if (retry_inc < RETRY_W'(MAX_RETRY)) begin
                        state_nxt = WR_START;
                        step_nxt  = '0;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ts4231_configurator.sv
// Bench for ts4231_configurator with a behavioural TS4231 model on pulled-up D/E pads.
module tb_ts4231_configurator;
    import ts4231_pkg::*;

    logic        clk_96MHz = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        d_oe, d_out, e_oe, e_out;
    logic        d_in = 1'b1;
    logic        e_in = 1'b1;
    logic        busy, configured, error;
    logic [14:0] readback;

    always #5 clk_96MHz = ~clk_96MHz;

    ts4231_configurator #(
        .CONFIG_WORD(15'h392B),
        .HALF_TICKS (4),
        .LIGHT_TICKS(16),
        .MAX_RETRY  (3)
    ) dut (
        .clk_96MHz (clk_96MHz),
        .reset     (reset),
        .start     (start),
        .d_oe      (d_oe),
        .d_out     (d_out),
        .d_in      (d_in),
        .e_oe      (e_oe),
        .e_out     (e_out),
        .e_in      (e_in),
        .busy      (busy),
        .configured(configured),
        .error     (error),
        .readback  (readback)
    );

    // Sensor model: records D on each driven E rise, echoes the last written
    // word (optionally with bit 0 flipped) while D is released and E is driven.
    logic        light = 1'b1;
    logic [1:0]  corrupt_mode = 2'd0;
    int unsigned round_base = 0;
    logic [15:0] hist = '0;
    logic [14:0] echo = '0;
    int unsigned rd_cnt = 15;
    int unsigned rd_round = 0;
    logic        e_prev = 1'b1;
    logic        d_oe_prev = 1'b0;
    logic        pad_d, pad_e;

    always_comb begin
        if (d_oe)
            pad_d = d_out;
        else if (e_oe)
            pad_d = (rd_cnt < 15) ? echo[4'(14 - rd_cnt)] : 1'b1;
        else
            pad_d = light;
        pad_e = e_oe ? e_out : light;
    end

    always @(posedge clk_96MHz) begin
        d_in      <= pad_d;
        e_in      <= pad_e;
        e_prev    <= e_out;
        d_oe_prev <= d_oe;
        if (d_oe && e_oe && e_out && !e_prev)
            hist <= {hist[14:0], d_out};
        if (d_oe_prev && !d_oe && e_oe) begin
            rd_cnt   <= 0;
            rd_round <= rd_round + 1;
            echo     <= hist[15:1] ^ (((corrupt_mode == 2'd1) ||
                        (corrupt_mode == 2'd2 && rd_round == round_base)) ? 15'h0001 : 15'h0000);
        end else if (!d_oe && e_oe && e_prev && !e_out) begin
            rd_cnt <= rd_cnt + 1;
        end
    end

    int unsigned total = 0;
    int unsigned bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_seq(output int unsigned cyc);
        @(negedge clk_96MHz) start = 1'b1;
        @(negedge clk_96MHz) start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        cyc = 0;
        while (busy && cyc < 5000) begin
            cyc++;
            @(negedge clk_96MHz);
        end
        chk("busy_fall", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic        exp_cfg;
        logic        exp_err;
        logic [14:0] exp_rb;
        int unsigned exp_cycles;
    } vec_t;

    vec_t        vecs[3];
    int unsigned cyc;
    logic [21:0] idle_exp;
    logic [21:0] idle_seen;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {mode, configured, error, readback, busy cycles}; one round = 204 + 205 + 1
        vecs[0] = '{2'd0, 1'b1, 1'b0, 15'h392B, 426};
        vecs[1] = '{2'd1, 1'b0, 1'b1, 15'h392A, 1246};
        vecs[2] = '{2'd2, 1'b1, 1'b0, 15'h392B, 836};
        idle_exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0000};

        repeat (3) @(negedge clk_96MHz);
        reset = 1'b0;
        idle_seen = {d_oe, e_oe, d_out, e_out, busy, configured, error, readback};
        chk("reset_state", 32'(idle_seen), 32'(idle_exp));
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_96MHz);
            if ({d_oe, e_oe, d_out, e_out, busy, configured, error, readback} != idle_exp &&
                idle_seen == idle_exp)
                idle_seen = {d_oe, e_oe, d_out, e_out, busy, configured, error, readback};
        end
        chk("idle_hold", 32'(idle_seen), 32'(idle_exp));

        for (int i = 0; i < 3; i++) begin
            corrupt_mode = vecs[i].mode;
            round_base   = rd_round;
            run_seq(cyc);
            chk("vec_cycles", cyc, vecs[i].exp_cycles);
            chk("vec_configured", 32'(configured), 32'(vecs[i].exp_cfg));
            chk("vec_error", 32'(error), 32'(vecs[i].exp_err));
            chk("vec_readback", 32'(readback), 32'(vecs[i].exp_rb));
            chk("vec_lines", 32'({d_oe, e_oe, d_out, e_out}), 32'(4'b0011));
        end

        // Light drops after 15 high samples, then must be seen 16 more times.
        corrupt_mode = 2'd0;
        light = 1'b0;
        repeat (2) @(negedge clk_96MHz);
        start = 1'b1;
        @(negedge clk_96MHz) start = 1'b0;
        light = 1'b1;
        repeat (15) @(negedge clk_96MHz);
        light = 1'b0;
        @(negedge clk_96MHz);
        chk("light_cnt_15", 32'(dut.light_cnt), 32'd15);
        chk("light_no_write", 32'(e_oe), 32'd0);
        repeat (3) @(negedge clk_96MHz);
        chk("light_cleared", 32'(dut.light_cnt), 32'd0);
        light = 1'b1;
        cyc = 0;
        while (!e_oe && cyc < 100) begin
            @(negedge clk_96MHz);
            cyc++;
        end
        chk("light_restart", cyc, 17);
        cyc = 0;
        while (busy && cyc < 5000) begin
            @(negedge clk_96MHz);
            cyc++;
        end
        chk("light_configured", 32'({busy, configured, error}), 32'(3'b010));

        // Reset in the middle of the write frame.
        @(negedge clk_96MHz) start = 1'b1;
        @(negedge clk_96MHz) start = 1'b0;
        cyc = 0;
        while (!(dut.state == WR_BIT && dut.bit_idx == 4'd7) && cyc < 2000) begin
            @(negedge clk_96MHz);
            cyc++;
        end
        chk("reached_bit7", 32'(dut.bit_idx), 32'd7);
        reset = 1'b1;
        @(negedge clk_96MHz);
        chk("rst_lines", 32'({d_oe, e_oe, d_out, e_out, busy}), 32'(5'b00110));
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        run_seq(cyc);
        chk("post_rst_cycles", cyc, 426);
        chk("post_rst_result", 32'({configured, error, readback}), 32'({2'b10, 15'h392B}));

        // start coincident with reset: reset wins.
        @(negedge clk_96MHz);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk_96MHz);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk_96MHz);
        chk("rst_start_busy", 32'({busy, configured}), 32'(2'b00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
